// File: rtl/core_ex_muldiv.sv
// Iterative RV64IM multiply/divide unit for the Execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module core_ex_muldiv #(
    parameter int XLEN    = 64,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2:0]         funct3_i,
    input  logic               word_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [RFIDX_W-1:0] rd_idx_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    result_o,
    output logic [RFIDX_W-1:0] rd_idx_o,
    output logic               busy_o
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [2:0]         f3_q;
    logic               word_q;
    logic               neg_q;
    logic [RFIDX_W-1:0] rd_q;
    logic [XLEN-1:0]    result_q;
    logic [XLEN-1:0]    opnd;
    logic [2*XLEN-1:0]  prod;

    logic            accept;
    logic            div_op, a_sgn_op, b_sgn_op, a_neg, b_neg, neg_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, special_val, special_res;

    assign accept = in_valid_i & (state == IDLE) & ~flush_i;

    // Operand decode: sign handling, W-form extension and the two divide corner cases.
    assign div_op   = funct3_i[2];
    assign a_sgn_op = div_op ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign b_sgn_op = div_op ? ~funct3_i[0] : ~funct3_i[1];
    assign a_ext    = !word_i ? rs1_data_i
                              : {{HALF{a_sgn_op & rs1_data_i[HALF-1]}}, rs1_data_i[HALF-1:0]};
    assign b_ext    = !word_i ? rs2_data_i
                              : {{HALF{b_sgn_op & rs2_data_i[HALF-1]}}, rs2_data_i[HALF-1:0]};
    assign a_neg    = a_sgn_op & a_ext[XLEN-1];
    assign b_neg    = b_sgn_op & b_ext[XLEN-1];
    assign a_mag    = a_neg ? -a_ext : a_ext;
    assign b_mag    = b_neg ? -b_ext : b_ext;
    assign neg_in   = (div_op & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

    assign min_val  = word_i ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = div_op & (b_ext == '0);
    assign div_ovf  = div_op & ~funct3_i[0] & (a_ext == min_val) & (b_ext == '1);
    assign special  = div_zero | div_ovf;
    assign special_val = div_zero ? (funct3_i[1] ? a_ext : '1) : (funct3_i[1] ? '0 : a_ext);
    assign special_res = word_i ? {{HALF{special_val[HALF-1]}}, special_val[HALF-1:0]} : special_val;

    logic [XLEN:0]     mul_sum, div_shl;
    logic [XLEN-1:0]   div_diff, div_val, div_sgn, raw_res, fin_res;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_nxt, mul_full, mul_sgn;

    // prod holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    assign div_shl  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    assign div_ge   = div_shl >= {1'b0, opnd};
    assign div_diff = div_shl[XLEN-1:0] - opnd;
    assign prod_nxt = f3_q[2] ? {(div_ge ? div_diff : div_shl[XLEN-1:0]), prod[XLEN-2:0], div_ge}
                              : {mul_sum, prod[XLEN-1:1]};

    // W multiplies stop after HALF shifts, leaving the product HALF bits too high.
    assign mul_full = word_q ? (prod_nxt >> HALF) : prod_nxt;
    assign mul_sgn  = neg_q ? -mul_full : mul_full;
    assign div_val  = f3_q[1] ? prod_nxt[2*XLEN-1:XLEN] : prod_nxt[XLEN-1:0];
    assign div_sgn  = neg_q ? -div_val : div_val;
    assign raw_res  = f3_q[2] ? div_sgn
                    : ((f3_q[1:0] == 2'b00) ? mul_sgn[XLEN-1:0] : mul_sgn[2*XLEN-1:XLEN]);
    assign fin_res  = word_q ? {{HALF{raw_res[HALF-1]}}, raw_res[HALF-1:0]} : raw_res;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nxt = DONE;
            DONE: if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            opnd     <= '0;
            prod     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                f3_q   <= funct3_i;
                word_q <= word_i;
                neg_q  <= neg_in;
                rd_q   <= rd_idx_i;
                cnt    <= word_i ? CW'(HALF) : CW'(XLEN);
                if (special) begin
                    result_q <= special_res;
                end else if (div_op) begin
                    prod <= {{XLEN{1'b0}}, (word_i ? (a_mag << HALF) : a_mag)};
                    opnd <= b_mag;
                end else begin
                    prod <= {{XLEN{1'b0}}, b_mag};
                    opnd <= a_mag;
                end
            end else if (state == CALC) begin
                prod <= prod_nxt;
                cnt  <= cnt - CW'(1);
                if (cnt == CW'(1)) result_q <= fin_res;
            end
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign out_valid_o = (state == DONE);
    assign result_o    = result_q;
    assign rd_idx_o    = rd_q;

endmodule
